// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: RAW stall, branch flush and operand forwarding select.
// Optional forwarding mode is enabled by defining the macro FWD_EN.
module hazard_ctrl #(
    parameter int unsigned RA_W       = 2,
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned RF_BYPASS  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    output logic             stall_pc,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            ex_v_q, mem_v_q, wb_v_q;
    logic [RA_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic            ex_ld_q, mem_ld_q, wb_ld_q;

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic haz, br_flush;
    logic stall_int, bubble_int, flush_int;
    logic [1:0] fwd_a_int, fwd_b_int;

    logic unused_ld;
    assign unused_ld = ^{ex_ld_q, mem_ld_q, wb_ld_q};

    function automatic logic src_hit(input logic valid, input logic use_src,
                                     input logic [RA_W-1:0] src, input logic slot_v,
                                     input logic [RA_W-1:0] slot_rd);
        return valid & use_src & slot_v & (slot_rd == src);
    endfunction

    always_comb begin
        a_ex  = src_hit(id_valid, id_use1, id_rs1, ex_v_q, ex_rd_q);
        a_mem = src_hit(id_valid, id_use1, id_rs1, mem_v_q, mem_rd_q);
        a_wb  = src_hit(id_valid, id_use1, id_rs1, wb_v_q, wb_rd_q);
        b_ex  = src_hit(id_valid, id_use2, id_rs2, ex_v_q, ex_rd_q);
        b_mem = src_hit(id_valid, id_use2, id_rs2, mem_v_q, mem_rd_q);
        b_wb  = src_hit(id_valid, id_use2, id_rs2, wb_v_q, wb_rd_q);
    end

    assign br_flush = ex_br_taken & ex_v_q;

`ifdef FWD_EN
    // Only a load in EX cannot be forwarded in time.
    assign haz = (a_ex | b_ex) & ex_ld_q;

    always_comb begin
        fwd_a_int = 2'b00;
        fwd_b_int = 2'b00;
        if (!(haz || flush_int)) begin
            if (a_ex)       fwd_a_int = 2'b01;
            else if (a_mem) fwd_a_int = 2'b10;
            else if (a_wb)  fwd_a_int = 2'b11;
            if (b_ex)       fwd_b_int = 2'b01;
            else if (b_mem) fwd_b_int = 2'b10;
            else if (b_wb)  fwd_b_int = 2'b11;
        end
    end
`else
    logic wb_counts;
    assign wb_counts = (RF_BYPASS == 0);
    assign haz = a_ex | a_mem | (a_wb & wb_counts) | b_ex | b_mem | (b_wb & wb_counts);

    always_comb begin
        fwd_a_int = 2'b00;
        fwd_b_int = 2'b00;
    end
`endif

    always_comb begin
        flush_int  = br_flush | (state_q == StFlush);
        stall_int  = ~flush_int & haz;
        bubble_int = flush_int | stall_int;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (br_flush) begin
            fcnt_d  = 3'(BR_PENALTY - 1);
            state_d = (BR_PENALTY <= 1) ? StRun : StFlush;
        end else begin
            unique case (state_q)
                StRun, StStall: state_d = haz ? StStall : StRun;
                StFlush: begin
                    if (fcnt_q != 3'd0) fcnt_d = fcnt_q - 3'd1;
                    state_d = (fcnt_q <= 3'd1) ? StRun : StFlush;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((stall_int || flush_int) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StRun;
            fcnt_q   <= 3'd0;
            cnt_q    <= '0;
            ex_v_q   <= 1'b0;
            mem_v_q  <= 1'b0;
            wb_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
            ex_ld_q  <= 1'b0;
            mem_ld_q <= 1'b0;
            wb_ld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_ld_q  <= mem_ld_q;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_ld_q <= ex_ld_q;
            ex_v_q   <= id_valid & id_we & ~bubble_int;
            ex_rd_q  <= id_rd;
            ex_ld_q  <= id_is_load;
        end
    end

    // Outputs are held at zero while reset is asserted, before the first clearing edge.
    always_comb begin
        stall_pc    = reset & stall_int;
        bubble_idex = reset & bubble_int;
        flush_ifid  = reset & flush_int;
        fwd_a       = reset ? fwd_a_int : 2'b00;
        fwd_b       = reset ? fwd_b_int : 2'b00;
        state_o     = reset ? state_q : StRun;
        stall_cnt   = reset ? cnt_q : '0;
    end

endmodule
